// File: rtl/mem_stage_pkg.sv
// Shared types and default sizes for the memory stage of the 16-bit pipelined CPU.
package mem_stage_pkg;

  localparam int unsigned DATA_W_DEF         = 16;
  localparam int unsigned ADDR_W_DEF         = 10;
  localparam int unsigned REG_IDX_W          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-for-ack cycle counter; expired is raised in the waited cycle that reaches the limit.
module mem_timeout_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts earlier ack-less wait cycles; +1 includes the current one
  assign expired = enable && (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM -> data-RAM req/ack -> registered MEM/WB bundle.
// Optional wait-for-ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 mm_in,
  input  logic                 wm_in,
  input  logic                 wre_in,
  input  logic [REG_IDX_W-1:0] reg_dest_in,
  input  logic [DATA_W-1:0]    alu_result_in,
  input  logic [DATA_W-1:0]    store_data_in,
  output logic                 ready_out,
  output logic                 ram_req,
  output logic                 ram_wren,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic                 ram_ack,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic                 wb_valid,
  output logic                 wb_wre,
  output logic [REG_IDX_W-1:0] wb_reg_dest,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 mem_fault
);

  state_e                 state_q, state_d;
  logic                   ram_req_q, ram_req_d;
  logic                   ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
  logic                   cap_wre_q, cap_wre_d;
  logic [REG_IDX_W-1:0]   cap_dest_q, cap_dest_d;
  logic                   wb_valid_q, wb_valid_d;
  logic                   wb_wre_q, wb_wre_d;
  logic [REG_IDX_W-1:0]   wb_reg_dest_q, wb_reg_dest_d;
  logic [DATA_W-1:0]      wb_data_q, wb_data_d;
  logic                   accept;
  logic                   timeout_hit;

  assign accept = valid_in && (state_q == IDLE);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic mem_fault_q, mem_fault_d;

  mem_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept && mm_in),
    .enable  ((state_q == WAIT_ACK) && !ram_ack),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (timeout_hit)
  );

  always_comb begin
    mem_fault_d = timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_fault_q <= 1'b0;
    end else begin
      mem_fault_q <= mem_fault_d;
    end
  end

  assign mem_fault = mem_fault_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign mem_fault   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && mm_in) state_d = WAIT_ACK;
      WAIT_ACK: if (ram_ack || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_req_d     = ram_req_q;
    ram_wren_d    = ram_wren_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    cap_wre_d     = cap_wre_q;
    cap_dest_d    = cap_dest_q;
    wb_valid_d    = 1'b0;
    wb_wre_d      = wb_wre_q;
    wb_reg_dest_d = wb_reg_dest_q;
    wb_data_d     = wb_data_q;
    if (accept && !mm_in) begin
      wb_valid_d    = 1'b1;
      wb_wre_d      = wre_in;
      wb_reg_dest_d = reg_dest_in;
      wb_data_d     = alu_result_in;
    end else if (accept) begin
      ram_req_d   = 1'b1;
      ram_wren_d  = wm_in;
      ram_addr_d  = alu_result_in[ADDR_W-1:0];
      ram_wdata_d = store_data_in;
      cap_wre_d   = wre_in;
      cap_dest_d  = reg_dest_in;
    end else if (state_q == WAIT_ACK && (ram_ack || timeout_hit)) begin
      // ram_wren_q doubles as the load/store flag of the outstanding access
      ram_req_d     = 1'b0;
      ram_wren_d    = 1'b0;
      wb_valid_d    = 1'b1;
      wb_reg_dest_d = cap_dest_q;
      wb_wre_d      = 1'b0;
      if (ram_ack && !ram_wren_q) begin
        wb_wre_d  = cap_wre_q;
        wb_data_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      ram_req_q     <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      cap_wre_q     <= 1'b0;
      cap_dest_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_wre_q      <= 1'b0;
      wb_reg_dest_q <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ram_req_q     <= ram_req_d;
      ram_wren_q    <= ram_wren_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      cap_wre_q     <= cap_wre_d;
      cap_dest_q    <= cap_dest_d;
      wb_valid_q    <= wb_valid_d;
      wb_wre_q      <= wb_wre_d;
      wb_reg_dest_q <= wb_reg_dest_d;
      wb_data_q     <= wb_data_d;
    end
  end

  always_comb begin
    ready_out = (state_q == IDLE);
  end

  assign ram_req     = ram_req_q;
  assign ram_wren    = ram_wren_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_wre      = wb_wre_q;
  assign wb_reg_dest = wb_reg_dest_q;
  assign wb_data     = wb_data_q;

endmodule
